// File: rtl/im_loader.sv
// Instruction-memory loader.
// Receives a big-endian 16-bit word count followed by that many 16-bit
// instruction words (high byte first) over a valid/ready byte stream, and
// issues one instruction-memory write per word at addresses 0..N-1.
// A zero or oversized word count aborts the load and raises a sticky err.
module im_loader #(
  parameter int DEPTH = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic [7:0]  rx_data,
  input  logic        rx_vld,
  output logic        rx_rdy,
  output logic        we,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // One bit wider than the word count so that DEPTH up to 65536 compares safely.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_FINISH,
    S_ERROR
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_len_hi;    // high byte of the word count, waiting for the low byte
  logic [15:0] r_len;       // word count N for the load in progress
  logic [15:0] r_idx;       // index of the word currently being received/written
  logic [7:0]  r_data_hi;   // high byte of the instruction word being assembled
  logic [15:0] r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_err;

  logic        w_xfer;      // a byte moves on the next rising edge
  logic [15:0] w_len;       // word count formed from the held high byte and the incoming low byte
  logic        w_len_bad;   // word count is zero or larger than the memory
  logic        w_last;      // the word being written is the final one of the load

  assign w_xfer    = rx_vld & rx_rdy;
  assign w_len     = {r_len_hi, rx_data};
  assign w_len_bad = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH_W);
  assign w_last    = (r_idx == (r_len - 16'd1));

  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign err     = r_err;

  // State register; reset wins over every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    w_state_next = r_state;
    rx_rdy       = 1'b0;
    we           = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          w_state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          w_state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          w_state_next = w_len_bad ? S_ERROR : S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          w_state_next = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        rx_rdy = 1'b1;
        if (rx_vld) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        we           = 1'b1;
        w_state_next = w_last ? S_FINISH : S_DATA_HI;
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      S_ERROR: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture bytes on accepted transfers, stage the write, advance the index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_hi  <= 8'd0;
      r_len     <= 16'd0;
      r_idx     <= 16'd0;
      r_data_hi <= 8'd0;
      r_wr_addr <= 16'd0;
      r_wr_data <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_err <= 1'b0;
            r_idx <= 16'd0;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= rx_data;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len;
            // Set on entry to the error state so err is already high there.
            if (w_len_bad) begin
              r_err <= 1'b1;
            end
          end
        end
        S_DATA_HI: begin
          if (w_xfer) begin
            r_data_hi <= rx_data;
          end
        end
        S_DATA_LO: begin
          // Address and data only change here, so they stay put whenever we is low.
          if (w_xfer) begin
            r_wr_addr <= r_idx;
            r_wr_data <= {r_data_hi, rx_data};
          end
        end
        S_WRITE: begin
          if (!w_last) begin
            r_idx <= r_idx + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomised self-checking bench for im_loader.
// A byte-stream model computes the expected write list, done and err for
// each load; a negedge monitor records what the design actually did.
module tb_im_loader;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        rx_rdy;
  logic        we;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  im_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .rx_rdy     (rx_rdy),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [31:0] got_q[$];
  int          done_cnt = 0;
  int          dbl_pulse = 0;
  int          last_we_cyc = -1;
  int          done_cyc = -1;
  int          busy_fall_cyc = -1;
  logic        prev_we = 1'b0;
  logic        prev_done = 1'b0;
  logic        prev_busy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      got_q.push_back({wr_addr, wr_data});
      last_we_cyc <= cyc;
      if (prev_we) dbl_pulse <= dbl_pulse + 1;
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (prev_done) dbl_pulse <= dbl_pulse + 1;
    end
    if (prev_busy && busy === 1'b0) busy_fall_cyc <= cyc;
    prev_we   <= (we === 1'b1);
    prev_done <= (done === 1'b1);
    prev_busy <= (busy === 1'b1);
  end

  // ---------------- reference model ----------------
  logic [7:0]  tx_q[$];
  logic [31:0] exp_q[$];
  int          last_acc_cyc;

  function automatic bit len_ok(input logic [15:0] n);
    return (n != 16'd0) && (int'(n) <= DEPTH);
  endfunction

  task automatic mk_load(input logic [15:0] n);
    tx_q.delete();
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
    if (len_ok(n)) begin
      for (int i = 0; i < 2 * int'(n); i++) tx_q.push_back(8'($urandom));
    end
  endtask

  // Drive tx_q as a valid/ready stream; gap_pct idles rx_vld, noise pulses load_start.
  task automatic send_all(input int gap_pct, input bit noise);
    for (int k = 0; k < tx_q.size(); k++) begin
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        if ($urandom_range(99) < gap_pct) begin
          rx_vld = 1'b0;
        end else begin
          rx_vld  = 1'b1;
          rx_data = tx_q[k];
        end
        load_start = noise && ($urandom_range(7) == 0);
        acc = (rx_vld === 1'b1) && (rx_rdy === 1'b1);
        if (acc) last_acc_cyc = cyc;
        @(negedge clk);
        guard++;
        if (!acc && guard > 300) begin
          chk("rx_accept_timeout", 32'd0, 32'd1);
          rx_vld = 1'b0;
          load_start = 1'b0;
          return;
        end
      end
    end
    rx_vld     = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic do_load(input int gap_pct, input bit noise);
    logic [15:0] n;
    bit          bad;
    int          base_w;
    int          base_d;
    int          guard;
    n   = {tx_q[0], tx_q[1]};
    bad = !len_ok(n);
    exp_q.delete();
    if (!bad) begin
      for (int i = 0; i < int'(n); i++)
        exp_q.push_back({16'(i), tx_q[2 + 2 * i], tx_q[3 + 2 * i]});
    end
    base_w = got_q.size();
    base_d = done_cnt;

    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    chk("start_err_clear", {31'd0, err}, 32'd0);
    chk("start_busy", {31'd0, busy}, 32'd1);

    send_all(gap_pct, noise);
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("busy_release", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    chk($sformatf("n_writes N=%0d", n), got_q.size() - base_w, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base_w + i >= got_q.size()) break;
      chk($sformatf("wr[%0d]", i), got_q[base_w + i], exp_q[i]);
      if (got_q[base_w + i] !== exp_q[i]) break;
    end
    chk("done_count", done_cnt - base_d, bad ? 0 : 1);
    chk("err_flag", {31'd0, err}, {31'd0, bad});
    chk("single_cycle_pulses", dbl_pulse, 0);
    if (!bad) begin
      chk("done_after_last_we", done_cyc, last_we_cyc + 1);
      chk("busy_falls_after_done", busy_fall_cyc, done_cyc + 1);
    end else begin
      chk("err_busy_fall_within_2", {31'd0, (busy_fall_cyc - last_acc_cyc >= 1) &&
                                            (busy_fall_cyc - last_acc_cyc <= 2)}, 32'd1);
    end
    $display("load N=%0d gap=%0d%% noise=%0d: writes=%0d err=%0d", n, gap_pct, noise,
             got_q.size() - base_w, err);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_w;
    int base_d;
    logic [15:0] n;

    // Reset with traffic and a load request present: reset must win.
    rst_n      = 1'b0;
    load_start = 1'b1;
    rx_vld     = 1'b1;
    rx_data    = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_wr_addr", {16'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_no_writes", got_q.size(), 0);
    load_start = 1'b0;
    rx_vld     = 1'b0;
    rst_n      = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    $display("reset: outputs idle");

    // Back-to-back three-word load.
    tx_q = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    do_load(0, 1'b0);

    // Zero length, then a good load that must clear err on start.
    mk_load(16'd0);
    do_load(0, 1'b0);
    mk_load(16'd2);
    do_load(20, 1'b0);

    // One past the memory, then exactly the memory size.
    mk_load(16'(DEPTH + 1));
    do_load(0, 1'b0);
    mk_load(16'(DEPTH));
    do_load(10, 1'b0);
    chk("full_last_addr", {16'd0, got_q[got_q.size() - 1][31:16]}, 32'h0000_07FF);

    // Reset after the first write of a three-word load.
    tx_q   = '{8'h00, 8'h03, 8'h12, 8'h34};
    base_w = got_q.size();
    base_d = done_cnt;
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    send_all(0, 1'b0);
    rx_vld  = 1'b1;
    rx_data = 8'hAB;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    rx_vld = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_writes", got_q.size() - base_w, 1);
    chk("midrst_first_write", got_q[base_w], 32'h0000_1234);
    chk("midrst_no_done", done_cnt - base_d, 0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rx_rdy", {31'd0, rx_rdy}, 32'd0);
    chk("midrst_wr_data", {16'd0, wr_data}, 32'd0);
    $display("mid-load reset: writes=%0d done=%0d", got_q.size() - base_w, done_cnt - base_d);

    // load_start noise while busy must be ignored.
    mk_load(16'd5);
    do_load(30, 1'b1);

    // Random loads with random gaps and load_start noise.
    for (int t = 0; t < 14; t++) begin
      case ($urandom_range(9))
        0:       n = 16'd0;
        1:       n = 16'(DEPTH + 1 + $urandom_range(200));
        default: n = 16'($urandom_range(24, 1));
      endcase
      mk_load(n);
      do_load($urandom_range(60), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, meaning the number of 16-bit words in the instruction memory being written.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port load_start  input  1  single-cycle request to begin a load.
REQ-005 SHALL have port rx_data  input  8  incoming byte from the serial front end.
REQ-006 SHALL have port rx_vld  input  1  rx_data valid.
REQ-007 SHALL have port rx_rdy  output  1  loader accepts rx_data this cycle.
REQ-008 SHALL have port we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port wr_addr  output  16  instruction-memory write address.
REQ-010 SHALL have port wr_data  output  16  instruction word to write.
REQ-011 SHALL have port busy  output  1  load in progress; processor held.
REQ-012 SHALL have port done  output  1  one-cycle pulse on successful load completion.
REQ-013 SHALL have port err  output  1  sticky length error flag.

Function
REQ-014 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, FINISH, ERROR.
REQ-015 SHALL transfer a byte only on a rising edge where rx_vld and rx_rdy are both 1.
REQ-016 SHALL drive rx_rdy=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO; 0 in all other states.
REQ-017 SHALL, in IDLE with load_start=1, clear err, clear the word index to 0, and go to LEN_HI next cycle.
REQ-018 SHALL ignore load_start in every state other than IDLE.
REQ-019 SHALL receive a big-endian 16-bit word count N: LEN_HI byte -> N[15:8], LEN_LO byte -> N[7:0].
REQ-020 SHALL, after LEN_LO transfer, go to ERROR if N==0 or N>DEPTH, else to DATA_HI.
REQ-021 SHALL receive each instruction word high byte first (DATA_HI -> bits 15:8, DATA_LO -> bits 7:0).
REQ-022 SHALL enter WRITE on the cycle after the DATA_LO transfer and assert we for exactly that one cycle, with wr_addr = current index (zero-extended) and wr_data = assembled word.
REQ-023 SHALL, leaving WRITE, go to FINISH if index==N-1, else increment index and go to DATA_HI.
REQ-024 SHALL assert done for exactly one cycle in FINISH, then return to IDLE.
REQ-025 SHALL, in ERROR, set err=1 for one cycle then return to IDLE with err held until the next accepted load_start or reset; no we is issued.
REQ-026 SHALL hold wr_addr and wr_data stable while we=0; they carry no meaning outside WRITE.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL tolerate arbitrary idle gaps on rx_vld in any receive state without losing or duplicating bytes.
REQ-029 SHALL produce exactly N write strobes at consecutive addresses 0..N-1 per successful load, never writing an address >= DEPTH.

Reset
REQ-030 SHALL, on a rising edge with rst_n=0, go to IDLE and set rx_rdy, we, busy, done, err to 0 and wr_addr, wr_data, index, N to 0.
REQ-031 SHALL, on reset mid-load, abandon the load with no further we; words already written remain in memory.
REQ-032 SHALL give rst_n priority over load_start and over any byte transfer in the same cycle.

Verification
REQ-033 SHALL pass: rst_n=0 for 2 cycles with rx_vld=1 -> all outputs 0, state IDLE, no we.
REQ-034 SHALL pass: load_start, bytes 00 03 12 34 AB CD 00 01 back-to-back -> we at (0,0x1234),(1,0xABCD),(2,0x0001), each one cycle; done pulses the cycle after the third we; busy falls with done.
REQ-035 SHALL pass: load_start, bytes 00 00 -> err=1 held, no we, busy=0 within 2 cycles; next load_start clears err.
REQ-036 SHALL pass: load_start, bytes 08 01 (N=2049) -> err=1, no we; then bytes 08 00 and 2048 words -> last we at addr 0x07FF, done pulse.
REQ-037 SHALL pass: rx_vld held 1 across WRITE -> rx_rdy=0 that cycle, byte held and accepted next cycle in DATA_HI, no duplication; random rx_vld gaps yield identical write sequence.
REQ-038 SHALL pass: load_start during busy ignored; rst_n=0 after first we of N=3 load -> no further we, busy=0, done never pulses.
